// File: rtl/mips_avalon_slave_ram.sv
// Avalon-MM responder word memory shared as unified instruction/data store.
// It inserts fixed or LFSR-chosen wait states and keeps a sticky protocol/range error flag.
module mips_avalon_slave_ram #(
  parameter int unsigned ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter bit          RAND_STALL  = 1'b0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        proto_err
);

  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam logic [29:0] BASE_W = BASE_ADDR[31:2];
  localparam logic [31:0] MOD    = 32'(WAIT_CYCLES + 1);

  typedef enum logic {S_IDLE = 1'b0, S_STALL = 1'b1} state_e;

  state_e            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [31:0]       target_q, target_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [31:0]       readdata_q;
  logic              proto_err_q;
  logic [69:0]       hold_q;
  logic [31:0]       mem [DEPTH];

  logic              req, stall, accept, in_range, changed, err_set;
  logic [31:0]       target_new, target_cur;
  logic [29:0]       woff;
  logic [ADDR_W-1:0] idx;

  // Word offset from the base; an unaligned or wrapped address falls out of range.
  assign req        = read | write;
  assign woff       = address[31:2] - BASE_W;
  assign in_range   = (address[1:0] == 2'b00) && ({2'b00, woff} < DEPTH);
  assign idx        = woff[ADDR_W-1:0];

  // The target only counts as latched once we are already stalling on this request.
  assign target_new = RAND_STALL ? ({24'd0, lfsr_q[7:0]} % MOD) : 32'(WAIT_CYCLES);
  assign target_cur = (state_q == S_STALL) ? target_q : target_new;
  assign stall      = req & (cnt_q < target_cur);
  assign waitrequest = ~reset_n | stall;
  assign accept     = req & ~waitrequest;

  assign changed = (state_q == S_STALL) &&
                   (hold_q != {address, read, write, byteenable, writedata});
  assign err_set = (accept & (~in_range | (read & write))) | changed;

  always_comb begin
    state_d  = S_IDLE;
    cnt_d    = '0;
    target_d = target_q;
    lfsr_d   = lfsr_q;
    if (req && (state_q == S_IDLE)) target_d = target_new;
    if (stall) begin
      state_d = S_STALL;
      cnt_d   = cnt_q + 32'd1;
    end
    if (accept) lfsr_d = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      target_q    <= '0;
      lfsr_q      <= 32'h1;
      readdata_q  <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      lfsr_q   <= lfsr_d;
      if (accept && read && !write) readdata_q <= in_range ? mem[idx] : '0;
      if (err_set) proto_err_q <= 1'b1;
    end
  end

  // Snapshot of the stalled request, compared next cycle to catch a master that lets go.
  always_ff @(posedge clk) begin
    if (stall) hold_q <= {address, read, write, byteenable, writedata};
  end

  always_ff @(posedge clk) begin
    if (accept && write && in_range) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) mem[idx][8*b +: 8] <= writedata[8*b +: 8];
      end
    end
  end

  assign readdata  = readdata_q;
  assign proto_err = proto_err_q;

endmodule
